// File: rtl/crv32_dbg_loader_if.sv
// Command stream and debug memory port of the crv32 debug loader.
// The loader uses the slave view; whatever feeds it commands and models memory uses master.
interface crv32_dbg_loader_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE = DATA_W / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              dbg_mem_op;
  logic [BE-1:0]     dbg_wren;
  logic [ADDR_W-1:0] dbg_adr;
  logic [DATA_W-1:0] dbg_do;
  logic [DATA_W-1:0] dbg_di;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, dbg_di,
    output cmd_ready, dbg_mem_op, dbg_wren, dbg_adr, dbg_do
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, dbg_di,
    input  cmd_ready, dbg_mem_op, dbg_wren, dbg_adr, dbg_do
  );
endinterface

// File: rtl/crv32_dbg_loader.sv
// Debug memory loader: executes address/write/mode/run commands on the SoC debug
// port, holding the CPU in reset until released, with optional read-back verify.
module crv32_dbg_loader #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  crv32_dbg_loader_if.slave bus,
  output logic             cpu_n_reset,
  output logic             busy,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);
  localparam int BE    = DATA_W / 8;
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int AMIN  = (ADDR_W < DATA_W) ? ADDR_W : DATA_W;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CMP, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE-1:0]     mask_q, mask_d;
  logic              verify_q, verify_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              cpu_q, cpu_d;
  logic              mem_op_q, mem_op_d;
  logic [BE-1:0]     wren_q, wren_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] do_q, do_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              accept, mismatch;

  function automatic logic [DATA_W-1:0] byte_mask(input logic [BE-1:0] m);
    logic [DATA_W-1:0] r;
    for (int b = 0; b < BE; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [ADDR_W-1:0] to_addr(input logic [DATA_W-1:0] d);
    logic [ADDR_W-1:0] a;
    a = '0;
    a[AMIN-1:0] = d[AMIN-1:0];
    return a;
  endfunction

  assign accept   = bus.cmd_valid && ready_q;
  assign mismatch = |((bus.dbg_di ^ data_q) & byte_mask(mask_q));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      mask_q    <= '1;
      verify_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      cpu_q     <= 1'b0;
      mem_op_q  <= 1'b0;
      wren_q    <= '0;
      adr_q     <= '0;
      do_q      <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      verify_q  <= verify_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      cpu_q     <= cpu_d;
      mem_op_q  <= mem_op_d;
      wren_q    <= wren_d;
      adr_q     <= adr_d;
      do_q      <= do_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  // Write payload is only meaningful while a sequence is active, so it carries no reset.
  always_ff @(posedge clk) data_q <= data_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    verify_d  = verify_q;
    data_d    = data_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    cpu_d     = cpu_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        case (bus.cmd_op)
          2'd0: addr_d = to_addr(bus.cmd_data);
          2'd1: begin
            state_d = S_WR;
            cnt_d   = '0;
            data_d  = bus.cmd_data;
          end
          2'd2: begin
            mask_d   = bus.cmd_data[BE-1:0];
            verify_d = bus.cmd_data[BE];
          end
          default: begin
            cpu_d   = bus.cmd_data[0];
            state_d = bus.cmd_data[0] ? S_RUN : S_IDLE;
          end
        endcase
      end
      S_WR: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          if (verify_q) begin
            state_d = S_RD;
          end else begin
            state_d = S_IDLE;
            addr_d  = addr_q + ADDR_W'(BE);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RD: state_d = S_CMP;
      S_CMP: begin
        state_d = S_IDLE;
        addr_d  = addr_q + ADDR_W'(BE);
        if (mismatch) begin
          err_d     = 1'b1;
          err_cnt_d = sat_inc(err_cnt_q);
        end
      end
      S_RUN: if (accept) begin
        // Only RUN is meaningful while the CPU executes; anything else is dropped.
        if (bus.cmd_op == 2'd3) begin
          cpu_d = bus.cmd_data[0];
          if (!bus.cmd_data[0]) state_d = S_IDLE;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Port values are decoded from the next state so every output leaves a flop.
  always_comb begin
    mem_op_d = (state_d == S_WR) || (state_d == S_RD);
    wren_d   = (state_d == S_WR) ? mask_d : '0;
    adr_d    = mem_op_d ? addr_d : adr_q;
    do_d     = (state_d == S_WR) ? data_d : do_q;
    busy_d   = (state_d == S_WR) || (state_d == S_RD) || (state_d == S_CMP);
    ready_d  = (state_d == S_IDLE) || (state_d == S_RUN);
  end

  assign bus.cmd_ready  = ready_q;
  assign bus.dbg_mem_op = mem_op_q;
  assign bus.dbg_wren   = wren_q;
  assign bus.dbg_adr    = adr_q;
  assign bus.dbg_do     = do_q;
  assign cpu_n_reset    = cpu_q;
  assign busy           = busy_q;
  assign err            = err_q;
  assign err_count      = err_cnt_q;
endmodule
